bram_port_arbiter: RTL and testbench

//  Shares one port of a dual-port block RAM among NREQ requesters (e.g. I-fetch, D-access, debug, DMA).

---
 rtl/bram_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 29 ++
 rtl/bram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
package bram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters, with optional
// post-reset RAM clear. Define BRAM_ARB_LOCK_EN to enable grant locking via lock[].
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int SCALE = 10,
  parameter int CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*SCALE-1:0] addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic [SCALE-1:0]      ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [SCALE-1:0] clr_addr, clr_nxt;
  logic [NREQ-1:0]  rvalid_nxt;

  logic [NREQ-1:0]  pick_oh, win_oh;
  logic [PW-1:0]    pick_idx, win_idx;
  logic             pick_any, win_any, hold;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef BRAM_ARB_LOCK_EN
  // owner is the last requester granted with lock set; it keeps the port
  // while it still requests and still holds lock.
  logic          owner_vld;
  logic [PW-1:0] owner;

  assign hold    = owner_vld && req[owner] && lock[owner];
  assign win_idx = hold ? owner : pick_idx;
  assign win_any = hold | pick_any;
  always_comb begin
    win_oh = pick_oh;
    if (hold) begin
      win_oh        = '0;
      win_oh[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_vld <= 1'b0;
      owner     <= '0;
    end else begin
      owner_vld <= (state == ST_RUN) && win_any && lock[win_idx];
      owner     <= win_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold        = 1'b0;
  assign win_idx     = pick_idx;
  assign win_any     = pick_any;
  assign win_oh      = pick_oh;
`endif

  assign rdata = ram_rdata;

  always_comb begin
    state_nxt  = state;
    clr_nxt    = clr_addr;
    ptr_nxt    = ptr;
    rvalid_nxt = '0;
    busy       = 1'b0;
    gnt        = '0;
    ram_oe     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        ram_oe   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        clr_nxt  = clr_addr + 1'b1;
        if (&clr_addr) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (win_any) begin
          gnt       = win_oh;
          ram_oe    = 1'b1;
          ram_we    = we[win_idx];
          ram_addr  = addr[int'(win_idx)*SCALE +: SCALE];
          ram_wdata = wdata[int'(win_idx)*WIDTH +: WIDTH];
          if (!we[win_idx]) rvalid_nxt = win_oh;
          // A locked hold leaves ptr where normal arbitration will resume.
          if (!hold)
            ptr_nxt = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLEAR != 0) ? ST_CLEAR : ST_RUN;
      ptr      <= '0;
      clr_addr <= '0;
      rvalid   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_addr <= clr_nxt;
      rvalid   <= rvalid_nxt;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: table vectors, read scoreboard, clear/reset sequences.
module tb_bram_port_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int S    = 4;

`ifdef BRAM_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic [NREQ-1:0]   req, we, lock, gnt, rvalid;
  logic [NREQ*S-1:0] addr;
  logic [NREQ*W-1:0] wdata;
  logic [W-1:0]      rdata, ram_wdata, ram_rdata;
  logic              ram_oe, ram_we;
  logic [S-1:0]      ram_addr;

  always #5 clk = ~clk;

  bram_port_arbiter #(.NREQ(NREQ), .WIDTH(W), .SCALE(S), .CLEAR(1)) dut (
    .clk(clk), .rst(rst), .busy(busy), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM port, 1-cycle read latency; seeded with garbage so the clear is visible.
  logic [W-1:0] mem [2**S];
  initial for (int i = 0; i < 2**S; i++) mem[i] = $urandom | 32'h1;
  always @(posedge clk) begin
    if (ram_oe) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [3:0]  abase;
    logic [31:0] wbase;
    logic [3:0]  exp_gnt;
  } vec_t;

  typedef struct {
    int          due;
    logic [3:0]  rv;
    logic [31:0] data;
  } sb_t;

  vec_t         tbl[$];
  sb_t          sb[$];
  logic [W-1:0] shadow [2**S];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  function automatic vec_t mk(input logic [3:0] r, w, l, ab, input logic [31:0] wb,
                              input logic [3:0] g);
    vec_t v;
    v.req = r; v.we = w; v.lock = l; v.abase = ab; v.wbase = wb; v.exp_gnt = g;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 of the following cycle.
  task automatic do_cycle(input vec_t v);
    int          idx;
    logic [3:0]  a;
    sb_t         e;
    req = v.req; we = v.we; lock = v.lock;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*S +: S]  = v.abase + 4'(i);
      wdata[i*W +: W] = v.wbase + 32'(i);
    end
    #3;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid", 32'(rvalid), 32'(e.rv));
      check("rdata", rdata, e.data);
    end else begin
      check("rvalid_idle", 32'(rvalid), 32'h0);
    end
    check("gnt", 32'(gnt), 32'(v.exp_gnt));
    if (v.exp_gnt != 4'h0) begin
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (v.exp_gnt[i]) idx = i;
      a = v.abase + 4'(idx);
      check("ram_addr", 32'(ram_addr), 32'(a));
      check("ram_oe_we", {30'h0, ram_oe, ram_we}, {30'h0, 1'b1, v.we[idx]});
      if (v.we[idx]) begin
        check("ram_wdata", ram_wdata, v.wbase + 32'(idx));
        shadow[a] = v.wbase + 32'(idx);
      end else begin
        e.due = cyc + 1; e.rv = v.exp_gnt; e.data = shadow[a];
        sb.push_back(e);
      end
    end else begin
      check("ram_oe_idle", 32'(ram_oe), 32'h0);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Walks the clear sweep from posedge+1. If stop_at is reached, returns at the sample
  // point of that cycle; otherwise returns at posedge+1 of the first RUN cycle.
  task automatic clear_phase(input int stop_at, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      #3;
      if (busy) begin
        check("clr_addr", 32'(ram_addr), 32'(n % (2**S)));
        check("clr_ctl", {25'h0, ram_oe, ram_we, gnt, |ram_wdata}, 32'b1100000);
        n++;
        if (n == stop_at) done = 1'b1;
        else begin @(posedge clk); #1; cyc++; end
      end else begin
        req = '0;
        @(posedge clk); #1; cyc++;
        done = 1'b1;
      end
    end
    if (!done) check("clr_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 2**S; i++) shadow[i] = '0;

    @(posedge clk); #1; @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_out", {24'h0, gnt, rvalid}, 32'h0);

    // Clear sweep; requests during clear must not be granted.
    rst = 1'b0;
    req = 4'b1111;
    clear_phase(0, n);
    check("clr_cycles", 32'(n), 32'd16);

    // All reads, every requester: gnt 0,1,2,3 repeating, reads addr 0..15 all zero.
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(4'b1111, 4'h0, 4'h0, 4'(k & 12), 32'h0, 4'(1 << (k % 4))));
    // Mixed writes/reads with ptr state carried between rows.
    tbl.push_back(mk(4'b0001, 4'b0001, 4'h0, 4'd3, 32'h5,   4'b0001));
    tbl.push_back(mk(4'b0010, 4'b0000, 4'h0, 4'd2, 32'h0,   4'b0010));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'd0, 32'h0,   4'b0000));
    tbl.push_back(mk(4'b1010, 4'b1000, 4'h0, 4'd4, 32'h100, 4'b1000));
    tbl.push_back(mk(4'b1010, 4'b0000, 4'h0, 4'd6, 32'h0,   4'b0010));
    tbl.push_back(mk(4'b1010, 4'b0000, 4'h0, 4'd3, 32'h0,   4'b1000));
    tbl.push_back(mk(4'b0101, 4'b0101, 4'h0, 4'd0, 32'hA0,  4'b0001));
    tbl.push_back(mk(4'b0101, 4'b0000, 4'h0, 4'd0, 32'h0,   4'b0100));
    tbl.push_back(mk(4'b0101, 4'b0000, 4'h0, 4'd0, 32'h0,   4'b0001));
    tbl.push_back(mk(4'b1111, 4'b1111, 4'h0, 4'd8, 32'h55,  4'b0010));
    tbl.push_back(mk(4'b0010, 4'b0000, 4'h0, 4'd8, 32'h0,   4'b0010));
    // Lone requester 2 toggling: granted every requested cycle, ptr lands on 3.
    tbl.push_back(mk(4'b0100, 4'b0000, 4'h0, 4'd1, 32'h0,   4'b0100));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'd1, 32'h0,   4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 4'h0, 4'd1, 32'h0,   4'b0100));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'd1, 32'h0,   4'b0000));
    tbl.push_back(mk(4'b0100, 4'b0000, 4'h0, 4'd1, 32'h0,   4'b0100));
    tbl.push_back(mk(4'b1111, 4'b0000, 4'h0, 4'd0, 32'h0,   4'b1000));
    // Lock: requester 0 holds for 3 cycles when enabled, else 0/1 alternation.
    tbl.push_back(mk(4'b0011, 4'b0000, 4'b0001, 4'd0, 32'h0, 4'b0001));
    tbl.push_back(mk(4'b0011, 4'b0000, 4'b0001, 4'd0, 32'h0, LOCK_ON ? 4'b0001 : 4'b0010));
    tbl.push_back(mk(4'b0011, 4'b0000, 4'b0001, 4'd0, 32'h0, 4'b0001));
    tbl.push_back(mk(4'b0011, 4'b0000, 4'b0000, 4'd0, 32'h0, 4'b0010));
    tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'd0, 32'h0, 4'b0000));

    foreach (tbl[i]) do_cycle(tbl[i]);

    // Reset together with a read grant: the pending rvalid must be dropped.
    req = 4'b0001; we = '0; lock = '0; rst = 1'b1;
    @(posedge clk); #1; cyc++;
    req = '0;
    check("rst_rvalid_drop", 32'(rvalid), 32'h0);
    check("rst_busy2", 32'(busy), 32'h1);
    rst = 1'b0;
    sb.delete();

    // Reset mid-clear at clr_addr 7 restarts the sweep from 0.
    clear_phase(8, n);
    check("clr_reach7", 32'(n), 32'd8);
    rst = 1'b1;
    @(posedge clk); #1; cyc++;
    check("clr_restart_addr", 32'(ram_addr), 32'h0);
    check("clr_restart_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    clear_phase(0, n);
    check("clr_cycles2", 32'(n), 32'd16);
    for (int i = 0; i < 2**S; i++) shadow[i] = '0;

    // Locations written earlier must read back zero after the second sweep.
    do_cycle(mk(4'b0001, 4'h0, 4'h0, 4'd7, 32'h0, 4'b0001));
    do_cycle(mk(4'b0010, 4'h0, 4'h0, 4'd8, 32'h0, 4'b0010));
    do_cycle(mk(4'b0000, 4'h0, 4'h0, 4'd2, 32'h0, 4'b0000));
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
